// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline hazard/flow controller.
// Covers FSM state encodings, shadow scoreboard entries and active-low polarities.
package hazard_ctrl_unit_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Active-low polarities used across the pipeline
  localparam logic WEN_LOAD          = 1'b0;
  localparam logic WEN_HOLD          = 1'b1;
  localparam logic REGWR_ON          = 1'b0;
  localparam logic REGWR_OFF         = 1'b1;
  localparam logic FF_APPLICABLE     = 1'b0;
  localparam logic FF_NOT_APPLICABLE = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } hcu_state_e;

  typedef struct packed {
    logic [REG_W-1:0] rdst;
    logic             wr;
    logic             load;
  } sb_entry_t;

  localparam sb_entry_t SB_INVALID = '{rdst: '0, wr: REGWR_OFF, load: 1'b0};

  // A load still in EX has no data yet, so EX forwarding excludes loads
  function automatic logic ff_applicable(sb_entry_t e, logic excl_load);
    return (e.wr == REGWR_ON && e.rdst != '0 && !(excl_load && e.load))
           ? FF_APPLICABLE : FF_NOT_APPLICABLE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_ctrl_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [hazard_ctrl_unit_pkg::REG_W-1:0] RegAName_D;
  logic [hazard_ctrl_unit_pkg::REG_W-1:0] RegBName_D;
  logic                                   UsesA_D;
  logic                                   UsesB_D;
  logic [hazard_ctrl_unit_pkg::REG_W-1:0] Rdst_D;
  logic                                   RegWrEn_D;
  logic                                   IsLoad_D;
  logic                                   halt_D;
  logic                                   BranchTaken_E;
  logic                                   mem_ready;

  logic                                   pc_hold;
  logic                                   stall_IF_ID;
  logic                                   nop_IF_ID;
  logic                                   stall_ID_EX;
  logic                                   nop_ID_EX;
  logic                                   WEN_EX_MEM;
  logic                                   nop_EX_MEM;
  logic                                   WEN_MEM_WB;
  logic                                   FF_EX_APPLICABLE;
  logic [hazard_ctrl_unit_pkg::REG_W-1:0] FF_EX_Rdst;
  logic                                   FF_MEM_APPLICABLE;
  logic [hazard_ctrl_unit_pkg::REG_W-1:0] FF_MEM_Rdst;
  logic                                   halt_out;
  logic [CNT_W-1:0]                       stall_count;
  logic [CNT_W-1:0]                       flush_count;

  modport master (
    output RegAName_D, RegBName_D, UsesA_D, UsesB_D, Rdst_D, RegWrEn_D,
           IsLoad_D, halt_D, BranchTaken_E, mem_ready,
    input  pc_hold, stall_IF_ID, nop_IF_ID, stall_ID_EX, nop_ID_EX,
           WEN_EX_MEM, nop_EX_MEM, WEN_MEM_WB, FF_EX_APPLICABLE, FF_EX_Rdst,
           FF_MEM_APPLICABLE, FF_MEM_Rdst, halt_out, stall_count, flush_count
  );

  modport slave (
    input  RegAName_D, RegBName_D, UsesA_D, UsesB_D, Rdst_D, RegWrEn_D,
           IsLoad_D, halt_D, BranchTaken_E, mem_ready,
    output pc_hold, stall_IF_ID, nop_IF_ID, stall_ID_EX, nop_ID_EX,
           WEN_EX_MEM, nop_EX_MEM, WEN_MEM_WB, FF_EX_APPLICABLE, FF_EX_Rdst,
           FF_MEM_APPLICABLE, FF_MEM_Rdst, halt_out, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_unit_scoreboard_stage.sv
// One shadow scoreboard entry tracking the destination of an in-flight instruction.
module hazard_scoreboard_stage
  import hazard_ctrl_unit_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      hold,
  input  logic      clear,
  input  sb_entry_t din,
  output sb_entry_t entry
);

  // Updates on the same edge as the pipeline registers it shadows
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      entry <= SB_INVALID;
    end else if (clear) begin
      entry <= SB_INVALID;
    end else if (!hold) begin
      entry <= din;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard and flow controller for the 5-stage pipeline: load-use stalls, branch
// flushes, data-memory freeze, halt drain, forwarding selects and perf counters.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input logic                CLK,
  input logic                RST,
  hazard_ctrl_unit_if.slave  bus
);

  localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  hcu_state_e        state, state_nxt;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic              stall_inc, flush_inc;
  logic              frz, load_use;
  logic              pc_hold_c, stall_if_id_c, nop_if_id_c, stall_id_ex_c, nop_id_ex_c;
  logic              wen_c;
  sb_entry_t         ent_d, ent_e, ent_m;

  assign ent_d = '{rdst: bus.Rdst_D, wr: bus.RegWrEn_D, load: bus.IsLoad_D};

  hazard_scoreboard_stage u_sb_e (
    .CLK   (CLK),
    .RST   (RST),
    .hold  (stall_id_ex_c),
    .clear (nop_id_ex_c),
    .din   (ent_d),
    .entry (ent_e)
  );

  hazard_scoreboard_stage u_sb_m (
    .CLK   (CLK),
    .RST   (RST),
    .hold  (wen_c == WEN_HOLD),
    .clear (1'b0),
    .din   (ent_e),
    .entry (ent_m)
  );

  assign load_use = ent_e.load && (ent_e.rdst != '0) &&
                    ((bus.UsesA_D && bus.RegAName_D == ent_e.rdst) ||
                     (bus.UsesB_D && bus.RegBName_D == ent_e.rdst));

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_RUN;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Priority: freeze > branch flush > load-use > halt
  always_comb begin
    state_nxt     = state;
    dcnt_nxt      = dcnt;
    frz           = 1'b0;
    pc_hold_c     = 1'b0;
    stall_if_id_c = 1'b0;
    nop_if_id_c   = 1'b0;
    stall_id_ex_c = 1'b0;
    nop_id_ex_c   = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if (!bus.mem_ready) begin
          frz       = 1'b1;
          stall_inc = 1'b1;
          state_nxt = ST_MEM_WAIT;
        end else begin
          state_nxt = ST_RUN;
          if (bus.BranchTaken_E) begin
            nop_if_id_c = 1'b1;
            nop_id_ex_c = 1'b1;
            flush_inc   = 1'b1;
          end else if (load_use) begin
            pc_hold_c     = 1'b1;
            stall_if_id_c = 1'b1;
            nop_id_ex_c   = 1'b1;
            stall_inc     = 1'b1;
          end else if (bus.halt_D) begin
            state_nxt = ST_DRAIN;
            dcnt_nxt  = DCNT_W'(DRAIN_CYCLES);
          end
        end
      end
      ST_DRAIN: begin
        if (!bus.mem_ready) begin
          frz       = 1'b1;
          stall_inc = 1'b1;
        end else begin
          pc_hold_c   = 1'b1;
          nop_if_id_c = 1'b1;
          if (dcnt <= DCNT_W'(1)) begin
            state_nxt = ST_HALTED;
            dcnt_nxt  = '0;
          end else begin
            dcnt_nxt = dcnt - DCNT_W'(1);
          end
        end
      end
      ST_HALTED: frz = 1'b1;
      default:   state_nxt = ST_RUN;
    endcase
    if (frz) begin
      pc_hold_c     = 1'b1;
      stall_if_id_c = 1'b1;
      stall_id_ex_c = 1'b1;
    end
  end

  assign wen_c = frz ? WEN_HOLD : WEN_LOAD;

  // Saturating performance counters
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Reset forces the pipeline controls to their idle values immediately
  assign bus.pc_hold           = RST & pc_hold_c;
  assign bus.stall_IF_ID       = RST & stall_if_id_c;
  assign bus.nop_IF_ID         = RST & nop_if_id_c;
  assign bus.stall_ID_EX       = RST & stall_id_ex_c;
  assign bus.nop_ID_EX         = RST & nop_id_ex_c;
  assign bus.WEN_EX_MEM        = RST & wen_c;
  assign bus.WEN_MEM_WB        = RST & wen_c;
  assign bus.nop_EX_MEM        = 1'b0;
  assign bus.FF_EX_APPLICABLE  = ff_applicable(ent_e, 1'b1);
  assign bus.FF_EX_Rdst        = ent_e.rdst;
  assign bus.FF_MEM_APPLICABLE = ff_applicable(ent_m, 1'b0);
  assign bus.FF_MEM_Rdst       = ent_m.rdst;
  assign bus.halt_out          = (state == ST_HALTED);
  assign bus.stall_count       = stall_cnt;
  assign bus.flush_count       = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the pipeline control rules.
module tb_hazard_ctrl_unit;

  localparam int unsigned CNT_W = 16;
  localparam int          DRAIN = 3;

  logic CLK = 1'b0;
  logic RST;

  hazard_ctrl_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl_unit #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]       ctl;  // pc_hold,stall_IF_ID,nop_IF_ID,stall_ID_EX,nop_ID_EX,WEN_EX_MEM,nop_EX_MEM,WEN_MEM_WB
    logic [11:0]      ff;   // FF_EX_APPLICABLE,FF_EX_Rdst,FF_MEM_APPLICABLE,FF_MEM_Rdst
    logic             halt;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model of the instructions sitting in EX and MEM, plus halt progress
  int e_rd, m_rd;
  bit e_wr, e_ld, m_wr, m_ld;
  bit halted;
  int drain_left;
  int n_stall, n_flush;

  task automatic model_reset();
    e_rd = 0; e_wr = 0; e_ld = 0;
    m_rd = 0; m_wr = 0; m_ld = 0;
    halted = 0; drain_left = 0; n_stall = 0; n_flush = 0;
  endtask

  function automatic logic [CNT_W-1:0] sat(input int n);
    return (n >= (2 ** CNT_W) - 1) ? '1 : CNT_W'(n);
  endfunction

  // One pipeline cycle: drive ID/EX/MEM inputs, push the expected control response
  task automatic step(input logic [4:0] ra, input logic [4:0] rb, input logic ua, input logic ub,
                      input logic [4:0] rd, input logic wen_n, input logic ld, input logic hlt,
                      input logic br, input logic mr, input logic rst);
    exp_t x;
    bit ph, sif, nif, sex, nex, frz, lu;
    @(negedge CLK);
    #1;
    bus.RegAName_D = ra; bus.RegBName_D = rb; bus.UsesA_D = ua; bus.UsesB_D = ub;
    bus.Rdst_D = rd; bus.RegWrEn_D = wen_n; bus.IsLoad_D = ld; bus.halt_D = hlt;
    bus.BranchTaken_E = br; bus.mem_ready = mr; RST = rst;
    ph = 0; sif = 0; nif = 0; sex = 0; nex = 0; frz = 0;
    if (!rst) begin
      model_reset();
      x.ctl = 8'h00; x.ff = {1'b1, 5'd0, 1'b1, 5'd0}; x.halt = 1'b0; x.sc = '0; x.fc = '0;
    end else begin
      x.halt = halted;
      x.sc   = sat(n_stall);
      x.fc   = sat(n_flush);
      x.ff   = {!(e_wr && e_rd != 0 && !e_ld), 5'(e_rd), !(m_wr && m_rd != 0), 5'(m_rd)};
      lu = e_ld && e_rd != 0 && ((ua && int'(ra) == e_rd) || (ub && int'(rb) == e_rd));
      if (halted) frz = 1;
      else if (!mr) begin frz = 1; n_stall++; end
      else if (drain_left > 0) begin
        ph = 1; nif = 1; drain_left--;
        if (drain_left == 0) halted = 1;
      end
      else if (br) begin nif = 1; nex = 1; n_flush++; end
      else if (lu) begin ph = 1; sif = 1; nex = 1; n_stall++; end
      else if (hlt) drain_left = DRAIN;
      if (frz) begin ph = 1; sif = 1; sex = 1; end
      x.ctl = {ph, sif, nif, sex, nex, frz, 1'b0, frz};
      if (!frz) begin m_rd = e_rd; m_wr = e_wr; m_ld = e_ld; end
      if (nex) begin e_rd = 0; e_wr = 0; e_ld = 0; end
      else if (!sex) begin e_rd = int'(rd); e_wr = !wen_n; e_ld = ld; end
    end
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one control response per cycle, sampled mid-cycle
  always @(posedge CLK) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("ctl", 32'({bus.pc_hold, bus.stall_IF_ID, bus.nop_IF_ID, bus.stall_ID_EX,
                      bus.nop_ID_EX, bus.WEN_EX_MEM, bus.nop_EX_MEM, bus.WEN_MEM_WB}), 32'(x.ctl));
      chk("fwd", 32'({bus.FF_EX_APPLICABLE, bus.FF_EX_Rdst,
                      bus.FF_MEM_APPLICABLE, bus.FF_MEM_Rdst}), 32'(x.ff));
      chk("halt_out", 32'(bus.halt_out), 32'(x.halt));
      chk("stall_count", 32'(bus.stall_count), 32'(x.sc));
      chk("flush_count", 32'(bus.flush_count), 32'(x.fc));
    end
  end

  initial begin
    logic [4:0] ra, rb, rd;
    logic ua, ub, wn, ld, hl, br, mr, rs;
    RST = 1'b0;
    bus.RegAName_D = '0; bus.RegBName_D = '0; bus.UsesA_D = 1'b0; bus.UsesB_D = 1'b0;
    bus.Rdst_D = '0; bus.RegWrEn_D = 1'b1; bus.IsLoad_D = 1'b0; bus.halt_D = 1'b0;
    bus.BranchTaken_E = 1'b0; bus.mem_ready = 1'b1;
    model_reset();

    // Reset with hostile inputs present
    step(5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 1, 1, 0, 0);
    step(5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 1, 1, 1, 0);
    // lw x5 ; add x6,x5,x1 -> one stall, then MEM forwarding of x5
    step(5'd0, 5'd0, 1, 0, 5'd5, 0, 1, 0, 0, 1, 1);
    step(5'd5, 5'd1, 1, 1, 5'd6, 0, 0, 0, 0, 1, 1);
    step(5'd5, 5'd1, 1, 1, 5'd6, 0, 0, 0, 0, 1, 1);
    // addi x3 ; add x4,x3,x3 -> EX forwarding; then rd=x0 is not forwardable
    step(5'd0, 5'd0, 1, 0, 5'd3, 0, 0, 0, 0, 1, 1);
    step(5'd3, 5'd3, 1, 1, 5'd4, 0, 0, 0, 0, 1, 1);
    step(5'd0, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0, 1, 1);
    step(5'd0, 5'd0, 1, 1, 5'd1, 0, 0, 0, 0, 1, 1);
    // Fresh run: branch coinciding with load-use flushes, no stall
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 1, 0);
    step(5'd0, 5'd0, 1, 0, 5'd7, 0, 1, 0, 0, 1, 1);
    step(5'd7, 5'd0, 1, 0, 5'd8, 0, 0, 0, 1, 1, 1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 1, 1);
    // Memory wait for 3 cycles
    step(5'd0, 5'd0, 1, 0, 5'd9, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(5'd9, 5'd0, 1, 0, 5'd10, 0, 0, 0, 1, 0, 1);
    step(5'd9, 5'd0, 1, 0, 5'd10, 0, 0, 0, 0, 1, 1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 1, 1);
    // Halt: drain then halted; reset while halted
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 1, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 1, 1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 1, 0);
    // Halt with two memory-wait cycles mid-drain
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 1, 0, 1, 1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 1, 1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 0, 1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 1, 1);
    // Reset during drain, then normal operation
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 1, 0);
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 1, 0, 1, 1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 1, 1);
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 1, 0);
    step(5'd0, 5'd0, 1, 0, 5'd2, 0, 1, 0, 0, 1, 1);
    step(5'd2, 5'd0, 1, 0, 5'd3, 0, 0, 0, 0, 1, 1);

    // Random traffic on a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      ra = 5'($urandom_range(0, 3));
      rb = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      ua = 1'($urandom_range(0, 1));
      ub = 1'($urandom_range(0, 1));
      wn = ($urandom_range(0, 99) < 25);
      ld = ($urandom_range(0, 99) < 40);
      hl = ($urandom_range(0, 99) < 2);
      br = ($urandom_range(0, 99) < 15);
      mr = ($urandom_range(0, 99) >= 15);
      rs = ($urandom_range(0, 99) >= 1);
      step(ra, rb, ua, ub, rd, wn, ld, hl, br, mr, rs);
    end

    repeat (2) @(negedge CLK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
